// File: rtl/pic16f84_fetch.sv
// Instruction fetch and Q1..Q4 phase sequencer for a PIC16F84-style core.
// Fetches the next word while the current op_code executes, with flush and hold.
module pic16f84_fetch (
    input  logic        clk,
    input  logic        mclr,
    input  logic        hold,
    input  logic [12:0] pc_in,
    input  logic        nop_in,
    input  logic [13:0] prog_data,
    output logic        q1,
    output logic        q2,
    output logic        q3,
    output logic        q4,
    output logic [13:0] op_code,
    output logic [9:0]  prog_addr,
    output logic        prog_rd,
    output logic [15:0] cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_Q1   = 3'd1,
        ST_Q2   = 3'd2,
        ST_Q3   = 3'd3,
        ST_Q4   = 3'd4,
        ST_HOLD = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [13:0] r_op_code;
    logic [13:0] r_prefetch;
    logic [9:0]  r_prog_addr;
    logic [15:0] r_cycle_count;
    logic        r_flush;
    logic        w_in_cycle;
    logic        w_cycle_end;
    logic        w_flush;
    logic        w_unused_pc;

    // The program memory is only 1K words, so the upper PC bits never reach it.
    assign w_unused_pc = ^pc_in[12:10];

    always_ff @(posedge clk) begin
        if (mclr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        q1           = 1'b0;
        q2           = 1'b0;
        q3           = 1'b0;
        q4           = 1'b0;
        case (r_state)
            ST_IDLE: if (!hold) w_next_state = ST_Q1;
            ST_Q1: begin
                q1           = 1'b1;
                w_next_state = ST_Q2;
            end
            ST_Q2: begin
                q2           = 1'b1;
                w_next_state = ST_Q3;
            end
            ST_Q3: begin
                q3           = 1'b1;
                w_next_state = ST_Q4;
            end
            ST_Q4: begin
                q4           = 1'b1;
                w_next_state = hold ? ST_HOLD : ST_Q1;
            end
            ST_HOLD: if (!hold) w_next_state = ST_Q1;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_in_cycle  = (r_state == ST_Q1) || (r_state == ST_Q2) ||
                         (r_state == ST_Q3) || (r_state == ST_Q4);
    assign w_cycle_end = (r_state == ST_Q4);
    assign w_flush     = r_flush | nop_in;

    // Address is launched on entry to Q2 so the ROM sees it together with the strobe.
    always_ff @(posedge clk) begin
        if (mclr) begin
            r_op_code     <= 14'h0000;
            r_prefetch    <= 14'h0000;
            r_prog_addr   <= 10'h000;
            r_cycle_count <= 16'h0000;
            r_flush       <= 1'b0;
        end else begin
            if (r_state == ST_Q1) begin
                r_prog_addr <= pc_in[9:0];
            end
            if (r_state == ST_Q3) begin
                r_prefetch <= prog_data;
            end
            if (w_cycle_end) begin
                r_op_code     <= w_flush ? 14'h0000 : r_prefetch;
                r_cycle_count <= r_cycle_count + 16'd1;
                r_flush       <= 1'b0;
            end else if (w_in_cycle) begin
                r_flush <= w_flush;
            end
        end
    end

    assign prog_rd     = (r_state == ST_Q2);
    assign op_code     = r_op_code;
    assign prog_addr   = r_prog_addr;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pic16f84_fetch.sv
// Self-checking bench for pic16f84_fetch: directed vector table, corner sequences,
// and randomized instruction cycles checked against an instruction-level model.
module tb_pic16f84_fetch;

    logic        clk = 1'b0;
    logic        mclr;
    logic        hold;
    logic [12:0] pc_in;
    logic        nop_in;
    logic [13:0] prog_data;
    logic        q1, q2, q3, q4;
    logic [13:0] op_code;
    logic [9:0]  prog_addr;
    logic        prog_rd;
    logic [15:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    logic [13:0] rom [1024];

    typedef struct {
        logic        mclr;
        logic        hold;
        logic [12:0] pc;
        logic        nop;
        logic [3:0]  q;
        logic [13:0] op;
        logic [9:0]  addr;
        logic        rd;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [19];

    logic [13:0] expOp;
    logic [15:0] expCnt;
    logic [9:0]  prevAddr;
    logic [12:0] rndPc;
    int          nopPh;
    int          stall;

    pic16f84_fetch dut (
        .clk         (clk),
        .mclr        (mclr),
        .hold        (hold),
        .pc_in       (pc_in),
        .nop_in      (nop_in),
        .prog_data   (prog_data),
        .q1          (q1),
        .q2          (q2),
        .q3          (q3),
        .q4          (q4),
        .op_code     (op_code),
        .prog_addr   (prog_addr),
        .prog_rd     (prog_rd),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears one clock after the read strobe.
    always @(posedge clk) begin
        if (prog_rd) prog_data <= rom[prog_addr];
    end

    function automatic vec_t mk(input logic m, input logic h, input logic [12:0] pc,
                                input logic n, input logic [3:0] q, input logic [13:0] op,
                                input logic [9:0] addr, input logic rd, input logic [15:0] cnt);
        vec_t v;
        v.mclr = m; v.hold = h; v.pc = pc; v.nop = n;
        v.q = q; v.op = op; v.addr = addr; v.rd = rd; v.cnt = cnt;
        return v;
    endfunction

    task automatic applyStimulus(input logic m, input logic h, input logic [12:0] pc,
                                 input logic n);
        mclr   = m;
        hold   = h;
        pc_in  = pc;
        nop_in = n;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] q, input logic [13:0] op,
                            input logic [9:0] addr, input logic rd, input logic [15:0] cnt);
        checkOutput({tag, "_q"}, {12'd0, q1, q2, q3, q4}, {12'd0, q});
        checkOutput({tag, "_op_code"}, {2'd0, op_code}, {2'd0, op});
        checkOutput({tag, "_prog_addr"}, {6'd0, prog_addr}, {6'd0, addr});
        checkOutput({tag, "_prog_rd"}, {15'd0, prog_rd}, {15'd0, rd});
        checkOutput({tag, "_cycle_count"}, cycle_count, cnt);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 14'($urandom);
        rom[0] = 14'h02B2;
        rom[5] = 14'h3008;

        // Pipeline fill, address wrap, flush in Q3, hold raised in Q2.
        vecs[0]  = mk(0, 0, 13'h0000, 0, 4'b1000, 14'h0000, 10'h000, 0, 16'd0);
        vecs[1]  = mk(0, 0, 13'h0000, 0, 4'b0100, 14'h0000, 10'h000, 1, 16'd0);
        vecs[2]  = mk(0, 0, 13'h0000, 0, 4'b0010, 14'h0000, 10'h000, 0, 16'd0);
        vecs[3]  = mk(0, 0, 13'h0000, 0, 4'b0001, 14'h0000, 10'h000, 0, 16'd0);
        vecs[4]  = mk(0, 0, 13'h0000, 0, 4'b1000, 14'h02B2, 10'h000, 0, 16'd1);
        vecs[5]  = mk(0, 0, 13'h1405, 0, 4'b0100, 14'h02B2, 10'h005, 1, 16'd1);
        vecs[6]  = mk(0, 0, 13'h1405, 0, 4'b0010, 14'h02B2, 10'h005, 0, 16'd1);
        vecs[7]  = mk(0, 0, 13'h1405, 1, 4'b0001, 14'h02B2, 10'h005, 0, 16'd1);
        vecs[8]  = mk(0, 0, 13'h1405, 0, 4'b1000, 14'h0000, 10'h005, 0, 16'd2);
        vecs[9]  = mk(0, 0, 13'h0005, 0, 4'b0100, 14'h0000, 10'h005, 1, 16'd2);
        vecs[10] = mk(0, 0, 13'h0005, 0, 4'b0010, 14'h0000, 10'h005, 0, 16'd2);
        vecs[11] = mk(0, 0, 13'h0005, 0, 4'b0001, 14'h0000, 10'h005, 0, 16'd2);
        vecs[12] = mk(0, 0, 13'h0005, 0, 4'b1000, 14'h3008, 10'h005, 0, 16'd3);
        vecs[13] = mk(0, 0, 13'h0000, 0, 4'b0100, 14'h3008, 10'h000, 1, 16'd3);
        vecs[14] = mk(0, 1, 13'h0000, 0, 4'b0010, 14'h3008, 10'h000, 0, 16'd3);
        vecs[15] = mk(0, 1, 13'h0000, 0, 4'b0001, 14'h3008, 10'h000, 0, 16'd3);
        vecs[16] = mk(0, 1, 13'h0000, 0, 4'b0000, 14'h02B2, 10'h000, 0, 16'd4);
        vecs[17] = mk(0, 1, 13'h0000, 0, 4'b0000, 14'h02B2, 10'h000, 0, 16'd4);
        vecs[18] = mk(0, 0, 13'h0000, 0, 4'b1000, 14'h02B2, 10'h000, 0, 16'd4);

        mclr = 1'b1; hold = 1'b0; pc_in = '0; nop_in = 1'b0;
        @(negedge clk);
        applyStimulus(1, 0, 13'h0000, 0);
        checkAll("reset", 4'b0000, 14'h0000, 10'h000, 1'b0, 16'd0);

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].mclr, vecs[i].hold, vecs[i].pc, vecs[i].nop);
            checkAll($sformatf("vec%0d", i), vecs[i].q, vecs[i].op, vecs[i].addr,
                     vecs[i].rd, vecs[i].cnt);
        end

        // Run on to Q3 with count 7, then reset with hold and nop also asserted.
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 13'h0000, 0);
        checkOutput("pre_reset_q3", {15'd0, q3}, 16'd1);
        checkOutput("pre_reset_count", cycle_count, 16'h0007);
        applyStimulus(1, 1, 13'h1FFF, 1);
        checkAll("midreset", 4'b0000, 14'h0000, 10'h000, 1'b0, 16'd0);
        applyStimulus(0, 1, 13'h0000, 0);
        checkAll("idle_hold1", 4'b0000, 14'h0000, 10'h000, 1'b0, 16'd0);
        applyStimulus(0, 1, 13'h0000, 0);
        checkAll("idle_hold2", 4'b0000, 14'h0000, 10'h000, 1'b0, 16'd0);
        applyStimulus(0, 0, 13'h0000, 0);
        checkAll("idle_release", 4'b1000, 14'h0000, 10'h000, 1'b0, 16'd0);

        // Counter wrap from a preloaded all-ones value.
        applyStimulus(0, 0, 13'h0000, 0);
        force dut.r_cycle_count = 16'hFFFF;
        applyStimulus(0, 0, 13'h0000, 0);
        release dut.r_cycle_count;
        applyStimulus(0, 0, 13'h0000, 0);
        checkOutput("wrap_q4", {15'd0, q4}, 16'd1);
        checkOutput("wrap_preload", cycle_count, 16'hFFFF);
        applyStimulus(0, 0, 13'h0000, 0);
        checkOutput("wrap_count", cycle_count, 16'h0000);
        checkOutput("wrap_q1", {15'd0, q1}, 16'd1);

        // Randomized cycles against an instruction-level model.
        applyStimulus(1, 0, 13'h0000, 0);
        applyStimulus(0, 0, 13'h0000, 0);
        expOp    = 14'h0000;
        expCnt   = 16'd0;
        prevAddr = 10'h000;
        for (int k = 0; k < 120; k++) begin
            rndPc = 13'($urandom);
            nopPh = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int p = 1; p <= 4; p++) begin
                checkAll("rnd", 4'(4'b1000 >> (p - 1)), expOp,
                         (p == 1) ? prevAddr : rndPc[9:0], p == 2, expCnt);
                applyStimulus(0, (p == 4) ? (stall > 0) : 1'($urandom_range(0, 1)),
                              rndPc, nopPh == p);
            end
            expOp    = (nopPh != 0) ? 14'h0000 : rom[rndPc[9:0]];
            expCnt   = expCnt + 16'd1;
            prevAddr = rndPc[9:0];
            for (int s = 1; s <= stall; s++) begin
                checkAll("rnd_hold", 4'b0000, expOp, prevAddr, 1'b0, expCnt);
                applyStimulus(0, s < stall, rndPc, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
